sargantana_icache_inval_ctrl: RTL and testbench

//  Invalidation/flush sequencer directly upstream of the icache replace unit.

---
 rtl/sargantana_icache_pkg.sv | 18 +
 rtl/sargantana_icache_inval_fifo.sv | 60 ++++++
 rtl/sargantana_icache_inval_ctrl.sv | 133 +++++++++++++
 tb/tb_sargantana_icache_inval_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the icache invalidation sequencer.
// Imported by the sequencer top and its invalidation FIFO.
package sargantana_icache_pkg;

    localparam int ICACHE_N_WAY     = 4;
    localparam int ICACHE_IDX_WIDTH = 6;
    localparam int ICACHE_NUM_SETS  = 2 ** ICACHE_IDX_WIDTH;
    localparam int INVAL_FIFO_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_FLUSH,
        ST_INVAL,
        ST_DONE
    } icache_inval_state_t;

endpackage

// File: rtl/sargantana_icache_inval_fifo.sv
// Small synchronous FIFO holding pending L2 set invalidations.
// Registered occupancy count; no push-to-pop bypass.
module sargantana_icache_inval_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == (PTR_W+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign head_o  = mem[rd_ptr];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sargantana_icache_inval_ctrl.sv
// Invalidation/flush sequencer feeding the icache replace unit.
// Walks all sets on reset and fence.i, then drains queued L2 invalidations.
module sargantana_icache_inval_ctrl
    import sargantana_icache_pkg::*;
#(
    parameter int ICACHE_N_WAY     = 4,
    parameter int ICACHE_IDX_WIDTH = 6,
    parameter int INVAL_FIFO_DEPTH = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_req_i,
    output logic                        flush_ack_o,
    input  logic                        l2_inval_valid_i,
    input  logic [ICACHE_IDX_WIDTH-1:0] l2_inval_idx_i,
    output logic                        l2_inval_ready_o,
    input  logic                        core_busy_i,
    output logic                        flush_ena_o,
    output logic                        inval_o,
    output logic [ICACHE_IDX_WIDTH-1:0] cline_index_o,
    output logic                        core_stall_o,
    output logic                        busy_o
);

    localparam logic [ICACHE_IDX_WIDTH-1:0] LAST_IDX = '1;

    if (ICACHE_N_WAY < 1 || INVAL_FIFO_DEPTH < 2 ||
        (INVAL_FIFO_DEPTH & (INVAL_FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("sargantana_icache_inval_ctrl: bad parameters");
    end

    icache_inval_state_t         state_q;
    icache_inval_state_t         state_d;
    logic [ICACHE_IDX_WIDTH-1:0] cnt_q;
    logic [ICACHE_IDX_WIDTH-1:0] cnt_d;
    logic                        from_flush_q;
    logic                        from_flush_d;
    logic                        q_full;
    logic                        q_empty;
    logic [ICACHE_IDX_WIDTH-1:0] q_head;
    logic                        q_pop;
    logic                        flush_ena;
    logic                        inval;
    logic                        ack;
    logic [ICACHE_IDX_WIDTH-1:0] cline;

    assign l2_inval_ready_o = ~q_full & ~rst_i;

    sargantana_icache_inval_fifo #(
        .WIDTH (ICACHE_IDX_WIDTH),
        .DEPTH (INVAL_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (l2_inval_valid_i & l2_inval_ready_o),
        .data_i  (l2_inval_idx_i),
        .pop_i   (q_pop),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (q_head)
    );

    // State, walk counter and ack-origin flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            from_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            from_flush_q <= from_flush_d;
        end
    end

    // Next state and array commands; a stalled walk holds its index.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        from_flush_d = from_flush_q;
        flush_ena    = 1'b0;
        inval        = 1'b0;
        ack          = 1'b0;
        q_pop        = 1'b0;
        cline        = cnt_q;
        unique case (state_q)
            ST_INIT, ST_FLUSH: begin
                if (!core_busy_i) begin
                    flush_ena = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                ack          = from_flush_q;
                from_flush_d = 1'b0;
                state_d      = ST_IDLE;
            end
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_d      = ST_FLUSH;
                    from_flush_d = 1'b1;
                end else if (!q_empty && !core_busy_i) begin
                    state_d = ST_INVAL;
                end
            end
            ST_INVAL: begin
                q_pop = 1'b1;
                inval = 1'b1;
                cline = q_head;
                if (flush_req_i) begin
                    state_d      = ST_FLUSH;
                    from_flush_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign flush_ena_o   = flush_ena & ~rst_i;
    assign inval_o       = inval & ~rst_i;
    assign flush_ack_o   = ack & ~rst_i;
    assign cline_index_o = rst_i ? '0 : cline;
    assign busy_o        = (state_q != ST_IDLE) | ~q_empty;
    assign core_stall_o  = (state_q != ST_IDLE) | flush_req_i | ~q_empty;

endmodule

// File: tb/tb_sargantana_icache_inval_ctrl.sv
// Scoreboard bench for the icache invalidation sequencer.
// Stimulus queues expected array commands; a monitor checks them in order.
module tb_sargantana_icache_inval_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush_req = 1'b0;
    logic       flush_ack;
    logic       l2_valid = 1'b0;
    logic [5:0] l2_idx = '0;
    logic       l2_ready;
    logic       core_busy = 1'b0;
    logic       flush_ena;
    logic       inval;
    logic [5:0] cline;
    logic       core_stall;
    logic       busy;

    typedef struct {
        int kind;
        int idx;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  walk0_cyc = 0;
    int  ack_cyc = 0;

    sargantana_icache_inval_ctrl #(
        .ICACHE_N_WAY     (4),
        .ICACHE_IDX_WIDTH (6),
        .INVAL_FIFO_DEPTH (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_req_i      (flush_req),
        .flush_ack_o      (flush_ack),
        .l2_inval_valid_i (l2_valid),
        .l2_inval_idx_i   (l2_idx),
        .l2_inval_ready_o (l2_ready),
        .core_busy_i      (core_busy),
        .flush_ena_o      (flush_ena),
        .inval_o          (inval),
        .cline_index_o    (cline),
        .core_stall_o     (core_stall),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk_evt(int kind, int idx);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d idx %0d, expected none",
                     kind, idx);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.idx != idx) begin
                n_fail++;
                $display("FAIL event_order: got kind %0d idx %0d, expected kind %0d idx %0d",
                         kind, idx, e.kind, e.idx);
            end
        end
    endtask

    // Monitor: kind 0 = flush_ena, 1 = inval, 2 = flush_ack.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (flush_ena || inval) begin
                check("exclusive", int'(flush_ena & inval), 0);
            end
            if (flush_ena) begin
                if (cline == 6'd0) walk0_cyc = cyc;
                chk_evt(0, int'(cline));
            end
            if (inval) begin
                chk_evt(1, int'(cline));
            end
            if (flush_ack) begin
                ack_cyc = cyc;
                chk_evt(2, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic push_walk(int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{0, i});
    endtask

    task automatic push_ev(int kind, int idx);
        exp_q.push_back('{kind, idx});
    endtask

    task automatic wait_idle(string name);
        int k;
        for (k = 0; k < 400; k++) begin
            sample();
            if (!busy && !flush_req) break;
        end
        check({name, "_timeout"}, int'(k < 400), 1);
        check({name, "_drain"}, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[3];
        int acc;
        int guard;
        bit seen;
        bit r;

        // Reset values
        repeat (3) @(posedge clk);
        sample();
        check("rst_flush_ena", int'(flush_ena), 0);
        check("rst_inval", int'(inval), 0);
        check("rst_ack", int'(flush_ack), 0);
        check("rst_cline", int'(cline), 0);
        check("rst_ready", int'(l2_ready), 0);

        // Reset walk: 64 sets, no ack
        push_walk(64);
        tick();
        rst = 1'b0;
        wait_idle("init");
        check("init_stall", int'(core_stall), 0);
        check("init_ready", int'(l2_ready), 1);

        // fence.i walk with core_busy on walk cycles 10-14
        flush_req = 1'b1;
        push_walk(64);
        push_ev(2, 0);
        tick();
        flush_req = 1'b0;
        for (int c = 0; c < 69; c++) begin
            core_busy = (c >= 10 && c <= 14);
            if (c == 12) begin
                sample();
                check("stall_idx", int'(cline), 10);
                check("stall_ena", int'(flush_ena), 0);
                check("stall_core", int'(core_stall), 1);
            end
            tick();
        end
        core_busy = 1'b0;
        wait_idle("flush");
        check("flush_len", ack_cyc - walk0_cyc, 69);

        // Three L2 pushes back-to-back
        vals[0] = 5;
        vals[1] = 9;
        vals[2] = 12;
        push_ev(1, 5);
        push_ev(1, 9);
        push_ev(1, 12);
        acc = 0;
        guard = 0;
        seen = 1'b0;
        while (acc < 3 && guard < 20) begin
            l2_valid = 1'b1;
            l2_idx = 6'(vals[acc]);
            sample();
            if (acc == 2 && !seen) begin
                check("ready_full", int'(l2_ready), 0);
                seen = 1'b1;
            end
            r = l2_ready;
            tick();
            if (r) acc++;
            guard++;
        end
        l2_valid = 1'b0;
        check("push_all", acc, 3);
        wait_idle("inval3");

        // Second flush_req absorbed mid-walk, L2 push during walk
        flush_req = 1'b1;
        push_walk(64);
        push_ev(2, 0);
        push_ev(1, 3);
        tick();
        flush_req = 1'b0;
        for (int c = 0; c < 64; c++) begin
            flush_req = (c == 20);
            l2_valid = (c == 40);
            l2_idx = 6'd3;
            tick();
        end
        flush_req = 1'b0;
        l2_valid = 1'b0;
        wait_idle("absorb");

        // Reset mid-walk with a pending queue entry
        rst = 1'b1;
        push_walk(31);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 31; c++) begin
            l2_valid = (c == 10);
            l2_idx = 6'd7;
            tick();
        end
        l2_valid = 1'b0;
        rst = 1'b1;
        sample();
        check("mid_rst_flush_ena", int'(flush_ena), 0);
        check("mid_rst_inval", int'(inval), 0);
        check("mid_rst_ack", int'(flush_ack), 0);
        check("mid_rst_cline", int'(cline), 0);
        check("mid_rst_ready", int'(l2_ready), 0);
        check("mid_rst_seen", exp_q.size(), 0);
        tick();
        push_walk(64);
        rst = 1'b0;
        wait_idle("rewalk");

        // flush_req and L2 push on the same IDLE cycle
        flush_req = 1'b1;
        l2_valid = 1'b1;
        l2_idx = 6'd44;
        push_walk(64);
        push_ev(2, 0);
        push_ev(1, 44);
        tick();
        flush_req = 1'b0;
        l2_valid = 1'b0;
        wait_idle("same_cycle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
